// File: rtl/ring_slot_mux.sv
`default_nettype none
// ============================================================================
// Module   : ring_slot_mux
// Summary  : Time-division multiplexer driven by a one-hot ring counter.
//            Each channel holds one pending word. On every enabled one-hot
//            slot, the selected channel's word moves into a single output
//            register that uses a valid/ready handshake. Multi-hot slot
//            vectors set a sticky error flag.
// Options  : RING_SLOT_MUX_MISS_CNT_EN adds a saturating 8-bit counter of
//            enabled slots that found their channel empty. Without it,
//            miss_cnt_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module ring_slot_mux #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 2
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           en_i,
  input  logic [N-1:0]   slot_i,
  input  logic [N-1:0]   ch_valid_i,
  input  logic [N*W-1:0] ch_data_i,
  output logic [N-1:0]   ch_ready_o,
  output logic           out_valid_o,
  output logic [W-1:0]   out_data_o,
  output logic [CW-1:0]  out_ch_o,
  input  logic           out_ready_i,
  output logic           err_o,
  output logic [7:0]     miss_cnt_o
);

  // Per-channel holding registers
  logic [W-1:0]  hold_q      [N];
  logic [W-1:0]  hold_d      [N];
  logic [N-1:0]  hold_full_q;
  logic [N-1:0]  hold_full_d;

  // Output register and sticky error
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [CW-1:0] out_ch_q,    out_ch_d;
  logic          err_q,       err_d;

  // Slot decode results
  logic          w_slot_any;
  logic          w_slot_multi;
  logic          w_slot_onehot;
  logic [CW-1:0] w_slot_idx;
  logic          w_sel_full;
  logic [W-1:0]  w_sel_word;
  logic          w_service;

  // Decode the slot vector: any bit set, more than one bit set, and the
  // holding state of the addressed channel (meaningful only when one-hot).
  always_comb begin
    w_slot_any   = 1'b0;
    w_slot_multi = 1'b0;
    w_slot_idx   = '0;
    w_sel_full   = 1'b0;
    w_sel_word   = '0;
    for (int i = 0; i < N; i++) begin
      if (slot_i[i]) begin
        if (w_slot_any) begin
          w_slot_multi = 1'b1;
        end
        w_slot_any = 1'b1;
        w_slot_idx = CW'(i);
        w_sel_full = hold_full_q[i];
        w_sel_word = hold_q[i];
      end
    end
  end

  assign w_slot_onehot = w_slot_any & ~w_slot_multi;

  // A transfer happens only when the output register is free or being
  // emptied in this same cycle, which gives one word per cycle at full rate.
  assign w_service = en_i & w_slot_onehot & w_sel_full &
                     (~out_valid_q | out_ready_i);

  assign ch_ready_o = ~hold_full_q & {N{~reset_i}};

  // One holding register per channel. A full register never reloads,
  // including in the cycle it drains, so ready rises one cycle after drain.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      logic w_load;
      logic w_drain;

      assign w_load  = ch_valid_i[gi] & ~hold_full_q[gi];
      assign w_drain = w_service & slot_i[gi];

      assign hold_full_d[gi] = w_drain ? 1'b0 : (w_load ? 1'b1 : hold_full_q[gi]);
      assign hold_d[gi]      = w_load ? ch_data_i[gi*W +: W] : hold_q[gi];

      // Holding register state
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          hold_full_q[gi] <= 1'b0;
          hold_q[gi]      <= '0;
        end else begin
          hold_full_q[gi] <= hold_full_d[gi];
          hold_q[gi]      <= hold_d[gi];
        end
      end
    end
  endgenerate

  // Next state for the output register and the sticky error.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    err_d       = err_q;
    if (w_service) begin
      out_valid_d = 1'b1;
      out_data_d  = w_sel_word;
      out_ch_d    = w_slot_idx;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
    if (en_i && w_slot_multi) begin
      err_d = 1'b1;
    end
  end

  // Output register and error flag state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_ch_o    = out_ch_q;
  assign err_o       = err_q;

`ifdef RING_SLOT_MUX_MISS_CNT_EN
  logic       w_empty_slot;
  logic [7:0] miss_cnt_q, miss_cnt_d;

  // Blocked, idle and multi-hot cycles are not misses.
  assign w_empty_slot = en_i & w_slot_onehot & ~w_sel_full;
  assign miss_cnt_d   = (w_empty_slot && (miss_cnt_q != 8'hFF)) ? miss_cnt_q + 8'd1
                                                                 : miss_cnt_q;

  // Saturating empty-slot counter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      miss_cnt_q <= 8'd0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_cnt_o = miss_cnt_q;
`else
  assign miss_cnt_o = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_slot_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_slot_mux
// Summary  : Self-checking bench for ring_slot_mux. Directed scenarios plus
//            randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_slot_mux;

  localparam int N = 4;
  localparam int W = 8;
`ifdef RING_SLOT_MUX_MISS_CNT_EN
  localparam bit c_MISS_EN = 1'b1;
`else
  localparam bit c_MISS_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic [N-1:0]   slot;
  logic [N-1:0]   ch_valid;
  logic [N*W-1:0] ch_data;
  logic [N-1:0]   ch_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_ready;
  logic           err;
  logic [7:0]     miss_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [N-1:0] m_full;
  logic [W-1:0] m_hold [N];
  logic         m_ov;
  logic [W-1:0] m_od;
  logic [1:0]   m_oc;
  logic         m_err;
  int           m_miss;

  ring_slot_mux #(.N(N), .W(W), .CW(2)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .en_i        (en),
    .slot_i      (slot),
    .ch_valid_i  (ch_valid),
    .ch_data_i   (ch_data),
    .ch_ready_o  (ch_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_ready_i (out_ready),
    .err_o       (err),
    .miss_cnt_o  (miss_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock; the model computes its next state from the current
  // inputs, then both model and DUT are observed 1ns after the edge.
  task automatic tick();
    logic [N-1:0] nf;
    logic [W-1:0] nh [N];
    logic         nov, nerr;
    logic [W-1:0] nod;
    logic [1:0]   noc;
    int           nmiss, ones, k;
    bit           served;
    nf = m_full; nh = m_hold; nov = m_ov; nod = m_od; noc = m_oc;
    nerr = m_err; nmiss = m_miss; served = 0;
    if (reset) begin
      nf = '0; nov = 0; nod = '0; noc = '0; nerr = 0; nmiss = 0;
      for (int i = 0; i < N; i++) nh[i] = '0;
    end else begin
      ones = $countones(slot);
      k = 0;
      for (int i = 0; i < N; i++) if (slot[i]) k = i;
      if (en && ones == 1) begin
        if (m_full[k] && (!m_ov || out_ready)) served = 1;
        else if (!m_full[k] && nmiss < 255) nmiss++;
      end
      if (en && ones > 1) nerr = 1;
      for (int i = 0; i < N; i++) begin
        if (ch_valid[i] && !m_full[i]) begin
          nf[i] = 1'b1;
          nh[i] = ch_data[i*W +: W];
        end
      end
      if (served) begin
        nf[k] = 1'b0; nov = 1'b1; nod = m_hold[k]; noc = k[1:0];
      end else if (m_ov && out_ready) begin
        nov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_full = nf; m_hold = nh; m_ov = nov; m_od = nod; m_oc = noc;
    m_err = nerr; m_miss = nmiss;
  endtask

  task automatic do_reset();
    reset = 1; en = 0; slot = '0; ch_valid = '0; out_ready = 1;
    tick();
    reset = 0;
  endtask

  task automatic load(input logic [N-1:0] v, input logic [N*W-1:0] d);
    en = 0; slot = '0; ch_valid = v; ch_data = d;
    tick();
    ch_valid = '0;
  endtask

  task automatic test_reset();
    reset = 1; en = 1; slot = '0; ch_valid = '0; ch_data = '0; out_ready = 1;
    tick(); tick();
    total++;
    if (ch_ready !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'h00 ||
        out_ch !== 2'd0 || err !== 1'b0 || miss_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b ov=%b od=%h oc=%0d err=%b miss=%0d required rdy=0000 rest 0",
               ch_ready, out_valid, out_data, out_ch, err, miss_cnt);
    end
    reset = 0; slot = 4'b0001;
    tick();
    total++;
    if (ch_ready !== 4'b1111 || out_valid !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rdy=%b ov=%b err=%b required rdy=1111 ov=0 err=0",
               ch_ready, out_valid, err);
    end
    slot = 4'b0010;
    tick();
    total++;
    if (ch_ready !== 4'b1111 || out_valid !== 1'b0 || out_data !== 8'h00 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_walk: rdy=%b ov=%b od=%h err=%b required 1111/0/00/0",
               ch_ready, out_valid, out_data, err);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] exp_rdy [4];
    logic         exp_ov  [4];
    exp_rdy = '{4'b0101, 4'b0111, 4'b0111, 4'b1111};
    exp_ov  = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    load(4'b1010, {8'h3C, 8'h00, 8'hA5, 8'h00});
    total++;
    if (ch_ready !== 4'b0101) begin
      bad++;
      $display("FAIL basic_load_ready: got=%b required=0101", ch_ready);
    end
    en = 1; out_ready = 1;
    for (int s = 0; s < 4; s++) begin
      slot = 4'b0001 << s;
      tick();
      total++;
      if (ch_ready !== exp_rdy[s] || out_valid !== exp_ov[s] ||
          (s == 1 && (out_data !== 8'hA5 || out_ch !== 2'd1)) ||
          (s == 3 && (out_data !== 8'h3C || out_ch !== 2'd3))) begin
        bad++;
        $display("FAIL basic_slot%0d: rdy=%b ov=%b od=%h oc=%0d required rdy=%b ov=%b",
                 s, ch_ready, out_valid, out_data, out_ch, exp_rdy[s], exp_ov[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    load(4'b1111, {words[3], words[2], words[1], words[0]});
    en = 1; out_ready = 1;
    for (int s = 0; s < 4; s++) begin
      slot = 4'b0001 << s;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== words[s] || out_ch !== s[1:0]) begin
        bad++;
        $display("FAIL b2b_word%0d: ov=%b od=%h oc=%0d required ov=1 od=%h oc=%0d",
                 s, out_valid, out_data, out_ch, words[s], s);
      end
    end
    slot = '0;
    tick();
    total++;
    if (out_valid !== 1'b0 || ch_ready !== 4'b1111) begin
      bad++;
      $display("FAIL b2b_drain: ov=%b rdy=%b required ov=0 rdy=1111", out_valid, ch_ready);
    end
  endtask

  task automatic test_blocked();
    do_reset();
    load(4'b0101, {8'h00, 8'hC3, 8'h00, 8'h5A});
    en = 1; out_ready = 0;
    slot = 4'b0001; tick();
    slot = 4'b0010; tick();
    slot = 4'b0100; tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ch !== 2'd0 || ch_ready[2] !== 1'b0) begin
      bad++;
      $display("FAIL blocked_hold: ov=%b od=%h oc=%0d rdy=%b required ov=1 od=5a oc=0 rdy[2]=0",
               out_valid, out_data, out_ch, ch_ready);
    end
    slot = 4'b1000; tick();
    out_ready = 1;
    slot = 4'b0001; tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL blocked_drain: ov=%b required 0", out_valid);
    end
    slot = 4'b0010; tick();
    slot = 4'b0100; tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_ch !== 2'd2) begin
      bad++;
      $display("FAIL blocked_retry: ov=%b od=%h oc=%0d required ov=1 od=c3 oc=2",
               out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_err();
    do_reset();
    load(4'b0101, {8'h00, 8'h77, 8'h00, 8'h66});
    out_ready = 1;
    en = 0; slot = 4'b0101; tick();
    total++;
    if (err !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL err_en_low: err=%b ov=%b required err=0 ov=0", err, out_valid);
    end
    en = 1; tick();
    total++;
    if (err !== 1'b1 || out_valid !== 1'b0 || ch_ready !== 4'b1010) begin
      bad++;
      $display("FAIL err_set: err=%b ov=%b rdy=%b required err=1 ov=0 rdy=1010",
               err, out_valid, ch_ready);
    end
    slot = 4'b0001; tick();
    total++;
    if (err !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h66) begin
      bad++;
      $display("FAIL err_sticky: err=%b ov=%b od=%h required err=1 ov=1 od=66",
               err, out_valid, out_data);
    end
    do_reset();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: err=%b required 0", err);
    end
  endtask

  task automatic test_miss();
    int exp;
    do_reset();
    en = 1; ch_valid = '0;
    for (int c = 0; c < 300; c++) begin
      slot = 4'b0001 << (c % 4);
      tick();
      if (c == 99) begin
        exp = c_MISS_EN ? 100 : 0;
        total++;
        if (miss_cnt !== exp[7:0]) begin
          bad++;
          $display("FAIL miss_count100: got=%0d required=%0d", miss_cnt, exp);
        end
      end
    end
    exp = c_MISS_EN ? 255 : 0;
    total++;
    if (miss_cnt !== exp[7:0]) begin
      bad++;
      $display("FAIL miss_saturate: got=%0d required=%0d", miss_cnt, exp);
    end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] exp_miss;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 3) != 0);
      r         = $urandom_range(0, 19);
      if (r == 0)      slot = '0;
      else if (r == 1) slot = 4'($urandom);
      else             slot = 4'b0001 << $urandom_range(0, 3);
      ch_valid  = 4'($urandom);
      ch_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      exp_miss = c_MISS_EN ? 8'(m_miss) : 8'd0;
      total++;
      if (ch_ready !== (~m_full & {N{~reset}}) || out_valid !== m_ov || out_data !== m_od ||
          out_ch !== m_oc || err !== m_err || miss_cnt !== exp_miss) begin
        bad++;
        $display("FAIL random_c%0d: rdy=%b ov=%b od=%h oc=%0d err=%b miss=%0d required rdy=%b ov=%b od=%h oc=%0d err=%b miss=%0d",
                 c, ch_ready, out_valid, out_data, out_ch, err, miss_cnt,
                 ~m_full & {N{~reset}}, m_ov, m_od, m_oc, m_err, exp_miss);
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_blocked();
    test_err();
    test_miss();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
